vc_rr_arbiter: RTL
==================

# vc_rr_arbiter

Parametrised round-robin virtual-channel arbiter for the router input stage. It selects one requesting VC out of NUM_VC, registers the grant, and holds it under a valid/ack handshake. In packet-lock mode it keeps the grant across flits until the tail flit is accepted. It replaces the combinational fixed-priority first-new-VC chain with a fair, stateful arbiter; a fixed-priority mode is retained for compatibility.

## Interface
- NUM_VC, 8: number of virtual channels; must be at least 2.
- IDX_W, $clog2(NUM_VC): width of the grant index.
- LOCK_PKT, 1: 1 holds the grant until `tail` is accepted; 0 releases after every accepted flit.
- FIXED_PRIO, 0: 1 keeps the search pointer at 0 (VC0 is always highest priority); 0 is round-robin.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- vc_isNew  input  NUM_VC  per-VC request; bit i high means VC i has a flit pending.
- ack  input  1  downstream accepts the granted flit this cycle.
- tail  input  1  qualifies `ack`; the accepted flit is the packet tail.
- isNew  output  1  registered OR of vc_isNew, sampled the previous cycle.
- grant_valid  output  1  a grant is being offered.
- grant  output  NUM_VC  one-hot grant; all zeros when grant_valid=0.
- firstPriority  output  IDX_W  index of the granted VC; holds its last value when grant_valid=0.

## Operation
- State machine with two states.
  - IDLE: grant_valid=0.
  - GRANT: grant_valid=1, and grant/firstPriority are stable.
- Search pointer `ptr` is an IDX_W register.
- Selection in IDLE when vc_isNew≠0:
  - The winner is the first set bit at index ptr, ptr+1, …, wrapping modulo NUM_VC.
  - The wrap is correct for non-power-of-2 NUM_VC; indices ≥ NUM_VC never occur.
  - Register grant, firstPriority and grant_valid, then go to GRANT.
- IDLE with vc_isNew=0: remain in IDLE.
- GRANT with ack=1:
  - If LOCK_PKT=0, or tail=1: ptr ← (winner+1) mod NUM_VC, go to IDLE.
  - Otherwise remain in GRANT with the same VC; ptr is unchanged.
- GRANT, ack=0, and the winner's vc_isNew bit is 0 (withdrawal): go to IDLE, ptr unchanged.
- ack and withdrawal in the same cycle: ack takes precedence and is handled as a normal accept.
- FIXED_PRIO=1: ptr is forced to 0 at all times, so the winner is the lowest set index.
- ack while in IDLE is ignored. tail without ack is ignored.
- Requests from other VCs while in GRANT are ignored; no preemption.

## Timing
- Reset values, one cycle after rst is sampled high:
  - state=IDLE, ptr=0
  - isNew=0, grant_valid=0, grant=0, firstPriority=0
- Reset mid-grant: the grant drops on the next edge; no ptr update.
- Request latency: vc_isNew sampled in IDLE at edge N; grant_valid=1 after edge N.
- Release: ack (with tail when LOCK_PKT=1) sampled at edge M; grant_valid=0 after edge M.
  - Earliest next grant appears after edge M+1.
  - Maximum grant rate is one every 2 cycles.
- isNew lags vc_isNew by exactly 1 cycle, independent of state.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

## Test plan
- Reset and basic grant (NUM_VC=8, RR, LOCK_PKT=0): assert rst for 2 cycles, then vc_isNew=8'b0010_0000.
  - During reset: all outputs 0.
  - Next cycle after the request: grant_valid=1, grant=8'h20, firstPriority=5.
- Round-robin fairness: hold vc_isNew=8'hFF and pulse ack each grant cycle.
  - Grants follow 0,1,2,…,7,0, one every 2 cycles.
- Wrap and non-power-of-2 (NUM_VC=5): ptr=4 after granting VC3, then vc_isNew=5'b00101.
  - Grant VC0, then VC2, with ptr wrap 4→0.
  - firstPriority never reaches 5–7.
- Packet lock (LOCK_PKT=1): VC2 granted, vc_isNew=8'h0C.
  - 3 acks with tail=0: grant stays VC2.
  - ack with tail=1: release; next grant is VC3.
- Withdrawal and simultaneous events:
  - VC6 granted, vc_isNew[6] drops with ack=0: IDLE next cycle, ptr stays 6.
  - Repeat with ack=1 in the same cycle: accept, ptr=7.
- Fixed priority (FIXED_PRIO=1): vc_isNew=8'hA4 held, repeated acks.
  - Always grants VC2.
  - After vc_isNew[2] clears: grants VC5.

Source files
------------

// File: rtl/vc_rr_arbiter.sv
// Round-robin virtual-channel arbiter: registers a one-hot grant and holds it under an
// ack handshake, optionally locking the grant for a whole packet until the tail is accepted.
module vc_rr_arbiter #(
  parameter int NUM_VC     = 8,
  parameter int IDX_W      = $clog2(NUM_VC),
  parameter bit LOCK_PKT   = 1'b1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_VC-1:0] vc_isNew,
  input  logic              ack,
  input  logic              tail,
  output logic              isNew,
  output logic              grant_valid,
  output logic [NUM_VC-1:0] grant,
  output logic [IDX_W-1:0]  firstPriority
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   prio_reg, prio_next;
  logic [NUM_VC-1:0]  grant_reg, grant_next;
  logic               isnew_reg;

  logic [IDX_W-1:0]   cand_idx [NUM_VC];
  logic [NUM_VC-1:0]  cand_req;
  logic [NUM_VC-1:0]  sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   prio_inc;

  // Candidate gi is the VC at distance gi from the pointer, wrapped by subtraction so
  // that non-power-of-2 channel counts never produce an out-of-range index.
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum           = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
    assign cand_idx[gi]  = (sum >= (IDX_W+1)'(NUM_VC)) ? IDX_W'(sum - (IDX_W+1)'(NUM_VC))
                                                       : sum[IDX_W-1:0];
    assign cand_req[gi]  = vc_isNew[cand_idx[gi]];
    assign sel_onehot[gi] = (sel_idx == IDX_W'(gi));
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (!sel_found && cand_req[k]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  assign prio_inc = (prio_reg == IDX_W'(NUM_VC - 1)) ? '0 : prio_reg + IDX_W'(1);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    prio_next  = prio_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next = GRANT;
          prio_next  = sel_idx;
          grant_next = sel_onehot;
        end
      end
      GRANT: begin
        // An accept wins over a simultaneous withdrawal of the granted request.
        if (ack) begin
          if (!LOCK_PKT || tail) begin
            ptr_next   = prio_inc;
            state_next = IDLE;
            grant_next = '0;
          end
        end else if (!vc_isNew[prio_reg]) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
    if (FIXED_PRIO) begin
      ptr_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      prio_reg  <= '0;
      grant_reg <= '0;
      isnew_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      prio_reg  <= prio_next;
      grant_reg <= grant_next;
      isnew_reg <= |vc_isNew;
    end
  end

  assign isNew         = isnew_reg;
  assign grant_valid   = (state_reg == GRANT);
  assign grant         = grant_reg;
  assign firstPriority = prio_reg;

endmodule
